// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and default sizing for the regfile write-port arbiter.
package regfile_wport_arbiter_pkg;

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W     = 5;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_NUM    = 32;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/regfile_wport_arbiter.sv
// Owns the regfile write port: clears r1..REG_NUM-1 after reset, then arbitrates
// between the WB stage (priority) and an aux writer with starvation protection.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_NUM    = DEF_REG_NUM,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              aux_valid,
  input  logic [ADDR_W-1:0] aux_waddr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ready,
  output logic              stall_req,
  output logic              init_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(REG_NUM - 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

  arb_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] init_cnt_reg, init_cnt_next;
  logic [SW-1:0]     starve_cnt_reg, starve_cnt_next;
  logic              grant_aux, grant_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_INIT;
      init_cnt_reg   <= ADDR_W'(1);
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Grants are only meaningful in RUN; the output mux below qualifies them.
  assign grant_aux = aux_valid && (!wb_we || starve_cnt_reg == STARVE_LIM);
  assign grant_wb  = wb_we && !grant_aux;

  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    rf_we           = 1'b0;
    rf_waddr        = '0;
    rf_wdata        = '0;
    aux_ready       = 1'b0;
    stall_req       = 1'b1;
    init_busy       = 1'b1;

    if (!rst) begin
      unique case (state_reg)
        ARB_INIT: begin
          rf_we         = 1'b1;
          rf_waddr      = init_cnt_reg;
          init_cnt_next = init_cnt_reg + ADDR_W'(1);
          if (init_cnt_reg == LAST_ADDR) begin
            state_next = ARB_RUN;
          end
        end
        ARB_RUN: begin
          init_busy = 1'b0;
          stall_req = 1'b0;
          if (grant_aux) begin
            rf_we     = 1'b1;
            rf_waddr  = aux_waddr;
            rf_wdata  = aux_wdata;
            aux_ready = 1'b1;
            stall_req = wb_we;
          end else if (grant_wb) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
          end
          // Aux waits only while it is actively losing to WB; a withdrawn request forfeits its credit.
          if (grant_aux || !aux_valid) begin
            starve_cnt_next = '0;
          end else if (grant_wb && starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + SW'(1);
          end
        end
        default: state_next = ARB_INIT;
      endcase
    end
  end

endmodule
